data_mem_unit: RTL and testbench

//  Multi-cycle data-memory stage downstream of the ALU. Takes the ALU result as
//  a byte address for LW/SW, runs a fixed-latency word access to an internal

---
 rtl/data_mem_unit.sv | 131 +++++++++++++
 tb/tb_data_mem_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Multi-cycle data-memory stage: fixed-latency word load/store with a stall
// handshake toward the control unit and rejection of misaligned/conflicting requests.
module data_mem_unit #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        mem_stall,
    output logic        mem_done,
    output logic        mem_err
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        din_q, din_d;
    logic               wr_q, wr_d;
    logic               err_q, err_d;
    logic [31:0]        dout_q, dout_d;
    logic [31:0]        mem_q [DEPTH];

    logic               req_s;
    logic               bad_s;
    logic               commit_s;
    logic               unused_addr_s;

    assign req_s    = mem_read | mem_write;
    assign bad_s    = (mem_read & mem_write) | (addr[1:0] != 2'b00);
    assign commit_s = (state_q == BUSY) && (cnt_q == 4'd0);

    // Address bits above the word index are deliberately ignored so accesses wrap.
    assign unused_addr_s = ^addr[31:IDX_W+2];

    // State, counter, latched request and load-data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            din_q   <= 32'd0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            din_q   <= din_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    // Word array; contents survive reset, and only the commit cycle of a store writes it.
    always_ff @(posedge clk) begin
        if (commit_s && wr_q) begin
            mem_q[idx_q] <= din_q;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, report for one cycle in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        din_d   = din_q;
        wr_d    = wr_q;
        err_d   = err_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (bad_s) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d   = addr[IDX_W+1:2];
                        din_d   = din;
                        wr_d    = mem_write;
                        cnt_d   = 4'(LATENCY - 1);
                        state_d = BUSY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!wr_q) begin
                        dout_d = mem_q[idx_q];
                    end else begin
                        dout_d = dout_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    // Stall drops in DONE so the PC advances on the edge that leaves DONE.
    assign mem_stall = ((state_q == IDLE) && req_s) || (state_q == BUSY);
    assign mem_done  = (state_q == DONE);
    assign mem_err   = (state_q == DONE) && err_q;
    assign dout      = dout_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: directed scenarios plus randomized
// traffic checked against a word-array reference model with spec-level timing.
module tb_data_mem_unit;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        mem_stall;
    logic        mem_done;
    logic        mem_err;

    int checks = 0;
    int passes = 0;

    // Reference model state: word array keyed by wrapped word index, and last load data.
    logic [31:0] ref_mem [int];
    logic [31:0] ref_dout;

    typedef struct packed {
        logic [31:0] done_at;
        logic [31:0] stall_n;
        logic        err;
        logic [31:0] dout;
    } res_t;

    always #5 clk = ~clk;

    data_mem_unit #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .mem_stall (mem_stall),
        .mem_done  (mem_done),
        .mem_err   (mem_err)
    );

    function automatic string fmt(input res_t r);
        return $sformatf("done@%0d stall=%0d err=%b dout=%h", r.done_at, r.stall_n, r.err, r.dout);
    endfunction

    // Expected outcome from the behavioural rules; updates the model on accepted accesses.
    task automatic model(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output res_t e);
        int idx;
        logic [1:0] lo;
        idx = int'((a / 32'd4) % DEPTH);
        lo  = a[1:0];
        if ((rd && wr) || lo != 2'b00) begin
            e.done_at = 32'd1;
            e.stall_n = 32'd1;
            e.err     = 1'b1;
        end else begin
            e.done_at = 32'(LATENCY + 1);
            e.stall_n = 32'(LATENCY + 1);
            e.err     = 1'b0;
            if (wr) ref_mem[idx] = d;
            else    ref_dout     = ref_mem[idx];
        end
        e.dout = ref_dout;
    endtask

    // Drives one request from a negedge, holds it until done, and reports what was seen.
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input bit tog, output res_t o);
        o.done_at = 32'hFFFF_FFFF;
        o.stall_n = 32'd0;
        o.err     = 1'bx;
        o.dout    = 32'hxxxx_xxxx;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        din       = d;
        for (int n = 0; n < 40 && o.done_at == 32'hFFFF_FFFF; n++) begin
            #1;
            if (mem_stall) o.stall_n = o.stall_n + 32'd1;
            if (mem_done) begin
                o.done_at = 32'(n);
                o.err     = mem_err;
                o.dout    = dout;
            end
            @(negedge clk);
            if (tog && o.done_at == 32'hFFFF_FFFF) begin
                addr = $urandom;
                din  = $urandom;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic op(input string nm, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d, input bit tog);
        res_t o, e;
        model(rd, wr, a, d, e);
        run_req(rd, wr, a, d, tog, o);
        checks++;
        if (o !== e) $display("FAIL %s: got %s, want %s", nm, fmt(o), fmt(e));
        else passes++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; addr = 32'd0; din = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (dout !== 32'd0)   $display("FAIL reset_dout: got %h, want 0", dout);      else passes++;
        checks++; if (mem_done !== 1'b0) $display("FAIL reset_done: got %b, want 0", mem_done); else passes++;
        checks++; if (mem_err !== 1'b0)  $display("FAIL reset_err: got %b, want 0", mem_err);   else passes++;
        checks++; if (mem_stall !== 1'b0) $display("FAIL reset_stall: got %b, want 0", mem_stall); else passes++;
        mem_read = 1'b1;
        #1;
        checks++; if (mem_stall !== 1'b1) $display("FAIL reset_req_stall: got %b, want 1", mem_stall); else passes++;
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ref_dout = 32'd0;
    endtask

    task automatic test_store_load();
        op("sw_0x10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        op("lw_0x10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        checks++; if (dout !== 32'hDEAD_BEEF) $display("FAIL lw_0x10_hold: got %h, want deadbeef", dout); else passes++;
    endtask

    task automatic test_misaligned();
        op("lw_0x12_err", 1'b1, 1'b0, 32'h12, 32'h0, 1'b0);
        op("sw_0x11_err", 1'b0, 1'b1, 32'h11, 32'h0BAD_0BAD, 1'b0);
        op("lw_0x10_intact", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    endtask

    task automatic test_conflict();
        op("sw_0x20", 1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
        op("rdwr_0x20_err", 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 1'b0);
        op("lw_0x20_intact", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    endtask

    task automatic test_wrap();
        op("sw_wrap", 1'b0, 1'b1, 32'(DEPTH * 4 + 4), 32'h55, 1'b0);
        op("lw_0x4", 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        checks++; if (dout !== 32'h55) $display("FAIL wrap_dout: got %h, want 00000055", dout); else passes++;
    endtask

    task automatic test_reset_mid_busy();
        op("sw_0x8_old", 1'b0, 1'b1, 32'h8, 32'hCAFE_F00D, 1'b0);
        mem_write = 1'b1; addr = 32'h8; din = 32'h1;
        @(negedge clk);
        #1;
        checks++; if (mem_stall !== 1'b1) $display("FAIL midbusy_stall: got %b, want 1", mem_stall); else passes++;
        reset = 1'b1;
        mem_write = 1'b0;
        #1;
        checks++;
        if ({mem_stall, mem_done, mem_err, dout} !== 35'd0)
            $display("FAIL midbusy_reset_outs: got stall=%b done=%b err=%b dout=%h, want all 0",
                     mem_stall, mem_done, mem_err, dout);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        ref_dout = 32'd0;
        op("lw_0x8_old", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        v = $urandom;
        op("b2b_sw_0x0", 1'b0, 1'b1, 32'h0, v, 1'b1);
        #1;
        checks++;
        if (mem_done !== 1'b0 || mem_stall !== 1'b0)
            $display("FAIL b2b_idle_gap: got done=%b stall=%b, want done=0 stall=0", mem_done, mem_stall);
        else passes++;
        op("b2b_lw_0x0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        checks++; if (dout !== v) $display("FAIL b2b_dout: got %h, want %h", dout, v); else passes++;
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic rd, wr;
        int r;
        for (int i = 0; i < 16; i++) op("rnd_init", 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) a = a + 32'(DEPTH * 4 * $urandom_range(1, 7));
            r = $urandom_range(0, 9);
            rd = (r != 0 && r < 6) || r == 9;
            wr = (r >= 6) || r == 0;
            op("rnd_op", rd, wr, a, $urandom, ($urandom_range(0, 1) == 1));
        end
    endtask

    initial begin
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; addr = 32'd0; din = 32'd0;
        ref_dout = 32'd0;
        test_reset();
        test_store_load();
        test_misaligned();
        test_conflict();
        test_wrap();
        test_reset_mid_busy();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
